// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: active-low 7-segment patterns {g,f,e,d,c,b,a} shared by the scan driver.
package seg_scan_driver_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef logic [1:0] digit_t;
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction
endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low a..g decoder with blanking.
module hex_to_seg7
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  assign o_seg = i_blank ? SEG_OFF : hex_seg(i_nib);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit hex display with per-frame latching,
// leading-zero blanking, decimal points and a dark guard at the start of each slot.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 10,
  parameter int unsigned BLANK_TICKS     = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Enable,
  input  logic [15:0] Value,
  input  logic [3:0]  DP_Mask,
  input  logic        LZB_En,
  output logic [7:0]  Segment7_0,
  output logic [7:0]  Segment7_1,
  output logic        Frame_Done
);
  localparam int unsigned TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;

  logic [TW-1:0] r_tick;
  digit_t        r_idx;
  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  logic          r_shadow_lzb;
  logic          r_loaded;
  logic          w_last_tick;
  logic          w_wrap;
  logic          w_dark;
  logic          w_blank;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;

  assign w_last_tick = r_tick == TW'(TICKS_PER_DIGIT - 1);
  assign w_wrap      = w_last_tick && r_idx == 2'd3;
  assign w_dark      = r_tick < TW'(BLANK_TICKS);
  assign w_nib       = r_shadow[{r_idx, 2'b00} +: 4];
  // A digit is a leading zero only when it and everything left of it is zero.
  assign w_blank     = r_shadow_lzb && (r_idx == 2'd3 ? r_shadow[15:12] == 4'h0 :
                                        r_idx == 2'd2 ? r_shadow[15:8] == 8'h00 :
                                        r_idx == 2'd1 ? r_shadow[15:4] == 12'h000 : 1'b0);

  hex_to_seg7 u_dec (
    .i_nib   (w_nib),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_shadow_lzb <= 1'b0;
      r_loaded     <= 1'b0;
      Segment7_0   <= 8'hFF;
      Segment7_1   <= 8'h00;
      Frame_Done   <= 1'b0;
    end else begin
      Frame_Done <= Enable && w_wrap;
      if (Enable) begin
        r_tick <= w_last_tick ? '0 : r_tick + 1'b1;
        if (w_last_tick) r_idx <= r_idx + 2'd1;
        if (!r_loaded || w_wrap) begin
          r_shadow     <= Value;
          r_shadow_dp  <= DP_Mask;
          r_shadow_lzb <= LZB_En;
          r_loaded     <= 1'b1;
        end
        Segment7_1 <= w_dark ? 8'h00 : {4'b0000, 4'b0001 << r_idx};
        Segment7_0 <= w_dark ? 8'hFF : {~r_shadow_dp[r_idx], w_seg};
      end else begin
        Segment7_1 <= 8'h00;
        Segment7_0 <= 8'hFF;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scoreboard bench for the multiplexed hex display driver.
module tb_seg_scan_driver;
  typedef struct {
    logic [7:0] seg;
    logic [7:0] en;
    logic       fd;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Enable;
  logic [15:0] Value;
  logic [3:0]  DP_Mask;
  logic        LZB_En;
  logic [7:0]  Segment7_0;
  logic [7:0]  Segment7_1;
  logic        Frame_Done;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fd = 0;
  int   fd_break = 0;
  int   seen_break = 0;
  bit   fd_valid = 1'b0;
  exp_t q[$];

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_scan_driver dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Enable     (Enable),
    .Value      (Value),
    .DP_Mask    (DP_Mask),
    .LZB_En     (LZB_En),
    .Segment7_0 (Segment7_0),
    .Segment7_1 (Segment7_1),
    .Frame_Done (Frame_Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] digit_pat(input logic [15:0] v, input logic [3:0] dp,
                                            input logic lzb, input int i);
    logic [15:0] upper;
    logic        blank;
    upper = v >> (4 * i);
    blank = lzb && i != 0 && upper == 16'h0;
    return {~dp[i], blank ? 7'h7F : HEX[upper[3:0]]};
  endfunction

  task automatic push_slot(input logic [7:0] seg, input logic [7:0] en, input bit last);
    q.push_back('{8'hFF, 8'h00, 1'b0});
    for (int k = 0; k < 9; k++) q.push_back('{seg, en, last && k == 8});
  endtask

  task automatic push_part(input logic [15:0] v, input logic [3:0] dp, input logic lzb,
                           input int from, input int upto);
    for (int p = from; p < upto; p++) begin
      if (p % 10 == 0) q.push_back('{8'hFF, 8'h00, 1'b0});
      else q.push_back('{digit_pat(v, dp, lzb, p / 10), 8'(1 << (p / 10)), p == 39});
    end
  endtask

  task automatic push_dark(input int n);
    for (int k = 0; k < n; k++) q.push_back('{8'hFF, 8'h00, 1'b0});
  endtask

  task automatic wait_left(input int n);
    int c = 0;
    while (q.size() > n && c < 500) begin
      @(negedge CLK);
      c++;
    end
    chk("queue_drain", 16'(q.size() > n), 16'h0);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    cyc++;
    chk("onehot", 16'($countones(Segment7_1) <= 1 && Segment7_1[7:4] == 4'h0), 16'h1);
    if (fd_break != seen_break) begin
      fd_valid   = 1'b0;
      seen_break = fd_break;
    end
    if (Frame_Done) begin
      if (fd_valid) chk("fd_period", 16'(cyc - last_fd), 16'd40);
      last_fd  = cyc;
      fd_valid = 1'b1;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("seg", {8'h00, Segment7_0}, {8'h00, e.seg});
      chk("en", {8'h00, Segment7_1}, {8'h00, e.en});
      chk("fd", {15'h0, Frame_Done}, {15'h0, e.fd});
    end
  end

  initial begin
    RST_N   = 1'b0;
    Enable  = 1'b1;
    Value   = 16'h1234;
    DP_Mask = 4'h0;
    LZB_En  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_seg", {8'h00, Segment7_0}, 16'h00FF);
    chk("rst_en", {8'h00, Segment7_1}, 16'h0000);
    chk("rst_fd", {15'h0, Frame_Done}, 16'h0000);
    RST_N = 1'b1;
    push_slot(8'h99, 8'h01, 1'b0);
    push_slot(8'hB0, 8'h02, 1'b0);
    push_slot(8'hA4, 8'h04, 1'b0);
    push_slot(8'hF9, 8'h08, 1'b1);
    wait_left(20);
    Value  = 16'h0005;
    LZB_En = 1'b1;
    push_part(16'h0005, 4'h0, 1'b1, 0, 40);
    wait_left(20);
    Value = 16'h0000;
    push_part(16'h0000, 4'h0, 1'b1, 0, 40);
    wait_left(20);
    Value  = 16'h1111;
    LZB_En = 1'b0;
    push_part(16'h1111, 4'h0, 1'b0, 0, 40);
    wait_left(25);
    Value = 16'h2222;
    push_part(16'h2222, 4'h0, 1'b0, 0, 40);
    wait_left(20);
    Value   = 16'h00AB;
    DP_Mask = 4'b0100;
    LZB_En  = 1'b1;
    push_part(16'h00AB, 4'b0100, 1'b1, 0, 40);
    wait_left(20);
    Value   = 16'hC0DE;
    DP_Mask = 4'b1001;
    LZB_En  = 1'b0;
    push_part(16'hC0DE, 4'b1001, 1'b0, 0, 25);
    push_dark(20);
    push_part(16'hC0DE, 4'b1001, 1'b0, 25, 40);
    wait_left(35);
    Enable = 1'b0;
    fd_break++;
    wait_left(15);
    Enable = 1'b1;
    wait_left(10);
    Value   = 16'hF00D;
    DP_Mask = 4'b0010;
    LZB_En  = 1'b1;
    chk("pre_rst_lit", {8'h00, Segment7_1}, 16'h0004);
    #2;
    RST_N = 1'b0;
    q.delete();
    fd_break++;
    #1;
    chk("async_seg", {8'h00, Segment7_0}, 16'h00FF);
    chk("async_en", {8'h00, Segment7_1}, 16'h0000);
    chk("async_fd", {15'h0, Frame_Done}, 16'h0000);
    repeat (2) @(negedge CLK);
    chk("hold_seg", {8'h00, Segment7_0}, 16'h00FF);
    RST_N = 1'b1;
    push_part(16'hF00D, 4'b0010, 1'b1, 0, 40);
    wait_left(0);
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
